motor_sequencer: RTL and testbench



---
 rtl/motor_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_motor_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : motor_sequencer
// Purpose  : Drives both ArtyBot motor H-bridges on Pmod JB. Generates
//            synchronous PWM on EN1/EN2 from speed commands and sequences DIR
//            changes through a forced-off dead time, so a bridge never sees a
//            direction flip while it is enabled.
// Ports    : clk         system clock
//            rst_n       asynchronous active-low reset
//            enable      master enable, low masks both EN outputs
//            cmd_valid   command present
//            cmd_ready   block can accept a command
//            cmd_rev     bit0 = left reverse, bit1 = right reverse
//            cmd_duty_l  left duty  (high time = value / 2^PWM_BITS)
//            cmd_duty_r  right duty
//            busy        command pending or dead time in progress
//            jb          jb[0]=EN1 jb[1]=DIR1 jb[4]=EN2 jb[5]=DIR2, rest 0
// Options  : MOTOR_RAMP_EN - when defined, active duties ramp 1 LSB per PWM
//            period toward the commanded target instead of stepping.
// Revision : 1.0 - initial release
// ============================================================================
module motor_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 16,
  parameter int DEADTIME = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_rev,
  input  logic [PWM_BITS-1:0] cmd_duty_l,
  input  logic [PWM_BITS-1:0] cmd_duty_r,
  output logic                busy,
  output logic [7:0]          jb
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DT_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [DT_W-1:0]     DT_LAST = DT_W'(DEADTIME - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_STOP   = 2'd1;
  localparam logic [1:0] ST_SWITCH = 2'd2;

  logic [1:0]          state, state_nx;
  logic [PS_W-1:0]     presc, presc_nx;
  logic [PWM_BITS-1:0] pwm_cnt, pwm_nx;
  logic [DT_W-1:0]     dead_cnt, dead_nx;
  logic [PWM_BITS-1:0] duty_l, duty_l_nx;
  logic [PWM_BITS-1:0] duty_r, duty_r_nx;
  logic                dir1, dir1_nx;
  logic                dir2, dir2_nx;
  logic                en1, en1_nx;
  logic                en2, en2_nx;
  logic                pending, pending_nx;
  logic [1:0]          pend_rev;
  logic [PWM_BITS-1:0] pend_l;
  logic [PWM_BITS-1:0] pend_r;

  logic tick;
  logic boundary;
  logic accept;
  logic want_dir1;
  logic want_dir2;
  logic dir_change;

  // Motors are mirrored: forward means DIR1=1, DIR2=0.
  assign want_dir1  = ~pend_rev[0];
  assign want_dir2  = pend_rev[1];
  assign dir_change = pending && ((want_dir1 != dir1) || (want_dir2 != dir2));

  assign tick     = (presc == PS_LAST);
  assign boundary = tick && (pwm_cnt == CNT_MAX);
  assign accept   = cmd_valid && cmd_ready;

  // Both handshake outputs come straight from the pending flop.
  assign cmd_ready = ~pending;
  assign busy      = pending;
  assign jb        = {2'b00, dir2, en2, 2'b00, dir1, en1};

`ifdef MOTOR_RAMP_EN
  function automatic logic [PWM_BITS-1:0] ramp_step(
    input logic [PWM_BITS-1:0] cur,
    input logic [PWM_BITS-1:0] tgt
  );
    if (cur < tgt) return cur + PWM_BITS'(1);
    if (cur > tgt) return cur - PWM_BITS'(1);
    return cur;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      presc    <= '0;
      pwm_cnt  <= '0;
      dead_cnt <= '0;
      duty_l   <= '0;
      duty_r   <= '0;
      dir1     <= 1'b1;
      dir2     <= 1'b0;
      en1      <= 1'b0;
      en2      <= 1'b0;
      pending  <= 1'b0;
      pend_rev <= '0;
      pend_l   <= '0;
      pend_r   <= '0;
    end else begin
      state    <= state_nx;
      presc    <= presc_nx;
      pwm_cnt  <= pwm_nx;
      dead_cnt <= dead_nx;
      duty_l   <= duty_l_nx;
      duty_r   <= duty_r_nx;
      dir1     <= dir1_nx;
      dir2     <= dir2_nx;
      en1      <= en1_nx;
      en2      <= en2_nx;
      pending  <= pending_nx;
      if (accept) begin
        pend_rev <= cmd_rev;
        pend_l   <= cmd_duty_l;
        pend_r   <= cmd_duty_r;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    if (dir_change) state_nx = ST_STOP;
      ST_STOP:   if (dead_cnt == DT_LAST) state_nx = ST_SWITCH;
      ST_SWITCH: state_nx = ST_RUN;
      default:   state_nx = ST_RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters, duties, direction and pending command
  // --------------------------------------------------------------------------
  always_comb begin
    presc_nx   = tick ? '0 : presc + PS_W'(1);
    pwm_nx     = tick ? pwm_cnt + PWM_BITS'(1) : pwm_cnt;
    dead_nx    = (state == ST_STOP) ? dead_cnt + DT_W'(1) : '0;
    duty_l_nx  = duty_l;
    duty_r_nx  = duty_r;
    dir1_nx    = dir1;
    dir2_nx    = dir2;
    // accept only happens while nothing is pending, so it never races a clear
    pending_nx = pending | accept;
    case (state)
      ST_RUN: begin
        // Same-direction updates wait for the period boundary so the new
        // duty starts on a clean pwm_cnt=0.
        if (pending && !dir_change && boundary) begin
`ifdef MOTOR_RAMP_EN
          duty_l_nx  = ramp_step(duty_l, pend_l);
          duty_r_nx  = ramp_step(duty_r, pend_r);
          pending_nx = !((duty_l_nx == pend_l) && (duty_r_nx == pend_r));
`else
          duty_l_nx  = pend_l;
          duty_r_nx  = pend_r;
          pending_nx = 1'b0;
`endif
        end
      end
      ST_SWITCH: begin
        // Restart the PWM frame together with the direction flip.
        dir1_nx  = want_dir1;
        dir2_nx  = want_dir2;
        presc_nx = '0;
        pwm_nx   = '0;
`ifdef MOTOR_RAMP_EN
        duty_l_nx  = '0;
        duty_r_nx  = '0;
        pending_nx = (pend_l != '0) || (pend_r != '0);
`else
        duty_l_nx  = pend_l;
        duty_r_nx  = pend_r;
        pending_nx = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: EN is computed from next-cycle values so the registered
  // jb bits line up with the counter and state of the cycle they appear in.
  // --------------------------------------------------------------------------
  always_comb begin
    en1_nx = enable && (state_nx == ST_RUN) && (pwm_nx < duty_l_nx);
    en2_nx = enable && (state_nx == ST_RUN) && (pwm_nx < duty_r_nx);
  end

endmodule
`default_nettype wire

// File: tb/tb_motor_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_motor_sequencer
// Purpose  : Self-checking bench for motor_sequencer (PWM_BITS=4,
//            PRESCALE=1, DEADTIME=8). Stimulus pushes cycle-stamped expected
//            jb/cmd_ready values into a queue; a monitor on the falling edge
//            pops and compares them, and also guards DIR changes against a
//            previously enabled bridge.
// Options  : MOTOR_RAMP_EN - runs the ramp sequence instead of step tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_sequencer;

  localparam int PERIOD = 16;

  typedef struct {
    int         cyc;
    logic [7:0] jb;
    logic       ready;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_rev = 2'b00;
  logic [3:0] cmd_duty_l = 4'd0;
  logic [3:0] cmd_duty_r = 4'd0;
  logic       cmd_ready;
  logic       busy;
  logic [7:0] jb;

  int cyc = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;

  motor_sequencer #(.PWM_BITS(4), .PRESCALE(1), .DEADTIME(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rev    (cmd_rev),
    .cmd_duty_l (cmd_duty_l),
    .cmd_duty_r (cmd_duty_r),
    .busy       (busy),
    .jb         (jb)
  );

  always #5 clk = ~clk;

  // Cycle index; with PRESCALE=1 the DUT pwm_cnt equals (cyc - base) % 16.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int ph(input int c);
    return (c - base) % PERIOD;
  endfunction

  function automatic logic [7:0] jbv(input logic e1, input logic d1,
                                     input logic e2, input logic d2);
    return {2'b00, d2, e2, 2'b00, d1, e1};
  endfunction

  task automatic push(input int c, input logic [7:0] j, input logic r);
    exp_t e;
    e.cyc = c;
    e.jb = j;
    e.ready = r;
    q.push_back(e);
  endtask

  // Expected window of n cycles at the given duties and directions.
  task automatic push_pwm(input int from, input int n, input int dl, input int dr,
                          input logic d1, input logic d2, input logic r);
    for (int c = from; c < from + n; c++)
      push(c, jbv(ph(c) < dl, d1, ph(c) < dr, d2), r);
  endtask

  task automatic wait_phase(input int p);
    int guard = 0;
    while (ph(cyc) != p && guard < 2 * PERIOD) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // Present a command so it is accepted on the edge where pwm_cnt becomes acc.
  task automatic issue(input logic [1:0] rev, input int dl, input int dr,
                       input int acc, output int n);
    wait_phase((acc + PERIOD - 1) % PERIOD);
    cmd_rev    = rev;
    cmd_duty_l = 4'(dl);
    cmd_duty_r = 4'(dr);
    cmd_valid  = 1'b1;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    n = cyc;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", q.size());
      q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  logic [7:0] prev_jb = 8'h00;
  bit         have_prev = 1'b0;

  always @(negedge clk) begin
    if (have_prev && ((jb[1] != prev_jb[1]) || (jb[5] != prev_jb[5]))) begin
      checks++;
      if (prev_jb[0] || prev_jb[4]) begin
        errors++;
        $display("FAIL dir_guard cyc %0d: jb=%h after jb=%h, required EN low before DIR change",
                 cyc, jb, prev_jb);
      end
    end
    prev_jb   = jb;
    have_prev = 1'b1;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.cyc != cyc) begin
        errors++;
        $display("FAIL stale_expect: expected cycle %0d reached at cycle %0d", mon_e.cyc, cyc);
      end else if (jb !== mon_e.jb || cmd_ready !== mon_e.ready || busy !== !mon_e.ready) begin
        errors++;
        $display("FAIL cyc %0d jb/ready/busy: got %h/%b/%b required %h/%b/%b",
                 cyc, jb, cmd_ready, busy, mon_e.jb, mon_e.ready, !mon_e.ready);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int n;
    int l;
    // Reset values, then idle after release.
    push(0, 8'h02, 1'b1);
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    push_pwm(cyc, 20, 0, 0, 1'b1, 1'b0, 1'b1);
    drain();

`ifdef MOTOR_RAMP_EN
    // Ramp 0 -> 3: one LSB per boundary, ready after the third.
    issue(2'b00, 3, 3, 4, n);
    l = n - 4 + PERIOD;
    push_pwm(n, l - n, 0, 0, 1'b1, 1'b0, 1'b0);
    push_pwm(l, 16, 1, 1, 1'b1, 1'b0, 1'b0);
    push_pwm(l + 16, 16, 2, 2, 1'b1, 1'b0, 1'b0);
    push_pwm(l + 32, 16, 3, 3, 1'b1, 1'b0, 1'b1);
    drain();
`else
    // Forward, duty 4 / 15, loads at the next boundary.
    issue(2'b00, 4, 15, 6, n);
    l = n - 6 + PERIOD;
    push_pwm(n, l - n, 0, 0, 1'b1, 1'b0, 1'b0);
    push_pwm(l, 32, 4, 15, 1'b1, 1'b0, 1'b1);
    drain();

    // Both duties to 8.
    issue(2'b00, 8, 8, 3, n);
    l = n - 3 + PERIOD;
    push_pwm(n, l - n, 4, 15, 1'b1, 1'b0, 1'b0);
    push_pwm(l, 16, 8, 8, 1'b1, 1'b0, 1'b1);
    drain();

    // Left reverse: 9 forced-off cycles, new DIR and pwm restart at N+10.
    issue(2'b01, 8, 8, 5, n);
    push(n, 8'h13, 1'b0);
    push_pwm(n + 1, 9, 0, 0, 1'b1, 1'b0, 1'b0);
    base = n + 10;
    push_pwm(n + 10, 16, 8, 8, 1'b0, 1'b0, 1'b1);
    drain();

    // Master enable low masks EN, resuming on the same phase.
    wait_phase(2);
    enable = 1'b0;
    push_pwm(cyc + 1, 6, 0, 0, 1'b0, 1'b0, 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    enable = 1'b1;
    push_pwm(cyc + 1, 20, 8, 8, 1'b0, 1'b0, 1'b1);
    drain();

    // Async reset in the middle of the dead time.
    issue(2'b00, 8, 8, 9, n);
    push_pwm(n, 4, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    push(0, 8'h02, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    base = 0;
    @(posedge clk); #1;
    push_pwm(cyc, 12, 0, 0, 1'b1, 1'b0, 1'b1);
    drain();

    // Accepted on a boundary edge: waits a full period. Left duty 0.
    issue(2'b00, 0, 1, 0, n);
    push_pwm(n, 16, 0, 0, 1'b1, 1'b0, 1'b0);
    push_pwm(n + 16, 32, 0, 1, 1'b1, 1'b0, 1'b1);
    drain();

    // Identical command accepted into the boundary cycle: applied next edge.
    issue(2'b00, 0, 1, 15, n);
    push_pwm(n, 1, 0, 1, 1'b1, 1'b0, 1'b0);
    push_pwm(n + 1, 16, 0, 1, 1'b1, 1'b0, 1'b1);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
